// File: rtl/axi4_lite_slave_regbank.sv
// AXI4-Lite slave backed by G_NB_REGS byte-strobed registers, exposed on a flat bus.
// Optional macro AXI4_LITE_SLAVE_DECERR_EN: out-of-range accesses answer DECERR instead of OKAY.
module axi4_lite_slave_regbank #(
  parameter int G_AXI4_LITE_ADDR_WIDTH = 32,
  parameter int G_AXI4_LITE_DATA_WIDTH = 32,
  parameter int G_NB_REGS              = 16
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               awvalid,
  input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]                  awaddr,
  input  logic [2:0]                                         awprot,
  output logic                                               awready,
  input  logic                                               wvalid,
  input  logic [G_AXI4_LITE_DATA_WIDTH-1:0]                  wdata,
  input  logic [G_AXI4_LITE_DATA_WIDTH/8-1:0]                wstrb,
  output logic                                               wready,
  output logic                                               bvalid,
  output logic [1:0]                                         bresp,
  input  logic                                               bready,
  input  logic                                               arvalid,
  input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]                  araddr,
  input  logic [2:0]                                         arprot,
  output logic                                               arready,
  output logic                                               rvalid,
  output logic [G_AXI4_LITE_DATA_WIDTH-1:0]                  rdata,
  output logic [1:0]                                         rresp,
  input  logic                                               rready,
  output logic [G_NB_REGS*G_AXI4_LITE_DATA_WIDTH-1:0]        regs_out,
  output logic                                               wr_pulse,
  output logic [((G_NB_REGS > 1) ? $clog2(G_NB_REGS) : 1)-1:0] wr_index
);

  localparam int AW       = G_AXI4_LITE_ADDR_WIDTH;
  localparam int DW       = G_AXI4_LITE_DATA_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = $clog2(SW);
  localparam int IDX_W    = (G_NB_REGS > 1) ? $clog2(G_NB_REGS) : 1;

  localparam logic [AW-1:0] NB_REGS_A = AW'(G_NB_REGS);
  localparam logic [1:0]    RESP_OKAY = 2'b00;
`ifdef AXI4_LITE_SLAVE_DECERR_EN
  localparam logic [1:0]    RESP_OOR  = 2'b11;
`else
  localparam logic [1:0]    RESP_OOR  = 2'b00;
`endif

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_RESP}         rstate_t;

  wstate_t r_wstate, w_wstate_next;
  rstate_t r_rstate, w_rstate_next;

  logic [DW-1:0]    r_regs [G_NB_REGS];

  // Held low through reset so readies only appear once rst_n has been sampled high.
  logic             r_ready_en;

  logic             r_aw_done;
  logic             r_w_done;
  logic [AW-1:0]    r_awaddr;
  logic [DW-1:0]    r_wdata;
  logic [SW-1:0]    r_wstrb;
  logic             r_bvalid;
  logic [1:0]       r_bresp;
  logic             r_wr_pulse;
  logic [IDX_W-1:0] r_wr_index;

  logic             r_rvalid;
  logic [1:0]       r_rresp;
  logic [DW-1:0]    r_rdata;

  logic             w_awready;
  logic             w_wready;
  logic             w_arready;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_ar_hs;

  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic             w_wr_in_range;
  logic             w_rd_in_range;
  logic [IDX_W-1:0] w_wr_sel;
  logic [IDX_W-1:0] w_rd_sel;

  logic             w_unused_prot;

  assign w_unused_prot = &{1'b0, awprot, arprot};

  // Byte-offset bits fall away in the shift; the full index is range-checked before truncation.
  assign w_wr_idx      = r_awaddr >> ADDR_LSB;
  assign w_rd_idx      = araddr >> ADDR_LSB;
  assign w_wr_in_range = (w_wr_idx < NB_REGS_A);
  assign w_rd_in_range = (w_rd_idx < NB_REGS_A);
  assign w_wr_sel      = w_wr_idx[IDX_W-1:0];
  assign w_rd_sel      = w_rd_idx[IDX_W-1:0];

  // ---------------- write FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wstate <= W_IDLE;
    end else begin
      r_wstate <= w_wstate_next;
    end
  end

  always_comb begin
    w_wstate_next = r_wstate;
    w_awready     = 1'b0;
    w_wready      = 1'b0;
    w_aw_hs       = 1'b0;
    w_w_hs        = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready = r_ready_en & ~r_aw_done;
        w_wready  = r_ready_en & ~r_w_done;
        w_aw_hs   = awvalid & w_awready;
        w_w_hs    = wvalid & w_wready;
        if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
          w_wstate_next = W_EXEC;
        end
      end
      W_EXEC: begin
        w_wstate_next = W_RESP;
      end
      W_RESP: begin
        if (bready) begin
          w_wstate_next = W_IDLE;
        end
      end
      default: begin
        w_wstate_next = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ready_en <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= 1'b0;
      r_wr_index <= '0;
    end else begin
      r_ready_en <= 1'b1;
      r_wr_pulse <= 1'b0;
      if (w_aw_hs) begin
        r_awaddr  <= awaddr;
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata  <= wdata;
        r_wstrb  <= wstrb;
        r_w_done <= 1'b1;
      end
      if (r_wstate == W_EXEC) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_in_range ? RESP_OKAY : RESP_OOR;
        if (w_wr_in_range) begin
          r_wr_pulse <= 1'b1;
          r_wr_index <= w_wr_sel;
        end
      end
      if ((r_wstate == W_RESP) && bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Register storage: only strobed lanes of an in-range target change at the EXEC edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < G_NB_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if ((r_wstate == W_EXEC) && w_wr_in_range) begin
      for (int b = 0; b < SW; b++) begin
        if (r_wstrb[b]) begin
          r_regs[w_wr_sel][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
      end
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rstate <= R_IDLE;
    end else begin
      r_rstate <= w_rstate_next;
    end
  end

  always_comb begin
    w_rstate_next = r_rstate;
    w_arready     = 1'b0;
    w_ar_hs       = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_arready = r_ready_en;
        w_ar_hs   = arvalid & r_ready_en;
        if (w_ar_hs) begin
          w_rstate_next = R_RESP;
        end
      end
      R_RESP: begin
        if (rready) begin
          w_rstate_next = R_IDLE;
        end
      end
      default: begin
        w_rstate_next = R_IDLE;
      end
    endcase
  end

  // A read sampled on the EXEC edge sees the pre-write contents (non-blocking update).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rresp  <= w_rd_in_range ? RESP_OKAY : RESP_OOR;
        r_rdata  <= w_rd_in_range ? r_regs[w_rd_sel] : '0;
      end else if ((r_rstate == R_RESP) && rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- outputs ----------------
  generate
    for (genvar gi = 0; gi < G_NB_REGS; gi++) begin : g_regs_out
      assign regs_out[gi*DW +: DW] = r_regs[gi];
    end
  endgenerate

  assign awready  = w_awready;
  assign wready   = w_wready;
  assign arready  = w_arready;
  assign bvalid   = r_bvalid;
  assign bresp    = r_bresp;
  assign rvalid   = r_rvalid;
  assign rresp    = r_rresp;
  assign rdata    = r_rdata;
  assign wr_pulse = r_wr_pulse;
  assign wr_index = r_wr_index;

endmodule

// File: tb/tb_axi4_lite_slave_regbank.sv
// Scoreboard bench for axi4_lite_slave_regbank: drivers push expectations, a negedge monitor checks.
// Honours AXI4_LITE_SLAVE_DECERR_EN for the expected out-of-range response code.
module tb_axi4_lite_slave_regbank;

  localparam int NR = 16;
`ifdef AXI4_LITE_SLAVE_DECERR_EN
  localparam logic [1:0] OOR_RESP = 2'b11;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0]   awaddr = '0, araddr = '0, wdata = '0;
  logic [3:0]    wstrb = '0;
  logic [2:0]    awprot = '0, arprot = '0;
  logic          awready, wready, bvalid, arready, rvalid, wr_pulse;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [NR*32-1:0] regs_out;
  logic [3:0]    wr_index;

  axi4_lite_slave_regbank #(
    .G_AXI4_LITE_ADDR_WIDTH(32), .G_AXI4_LITE_DATA_WIDTH(32), .G_NB_REGS(NR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arprot(arprot), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .regs_out(regs_out), .wr_pulse(wr_pulse), .wr_index(wr_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] model [NR];
  logic [1:0]  b_resp_q[$];
  int          b_cyc_q[$];
  int          idx_q[$];
  logic [33:0] r_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event not as required (cycle %0d)", name, cyc);
  endfunction

  function automatic void check_regs(input string name);
    int bad;
    bad = -1;
    for (int i = NR - 1; i >= 0; i--) begin
      if (regs_out[i*32 +: 32] !== model[i]) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: reg%0d actual=0x%0h required=0x%0h", name, bad, regs_out[bad*32 +: 32], model[bad]);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
  endfunction

  function automatic void flush_queues();
    b_resp_q.delete();
    b_cyc_q.delete();
    idx_q.delete();
    r_q.delete();
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    bit aw_pend = 0, w_pend = 0, ar_pend = 0;
    bit p_bvalid = 0, p_bhs = 0, p_rvalid = 0, p_rhs = 0, p_pulse = 0;
    logic [1:0] p_bresp = '0, p_rresp = '0;
    logic [31:0] p_rdata = '0;
    logic [33:0] r_exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        p_bvalid = 0; p_bhs = 0; p_rvalid = 0; p_rhs = 0; p_pulse = 0;
      end else begin
        if (aw_pend) chk("awready_low_until_b", awready, 0);
        if (w_pend)  chk("wready_low_until_b", wready, 0);
        if (ar_pend) chk("arready_low_until_r", arready, 0);
        if (p_bvalid && !p_bhs) begin
          chk("bvalid_held", bvalid, 1);
          chk("bresp_held", bresp, p_bresp);
        end
        if (p_rvalid && !p_rhs) begin
          chk("rvalid_held", rvalid, 1);
          chk("rresp_held", rresp, p_rresp);
          chk("rdata_held", rdata, p_rdata);
        end
        if (bvalid && !p_bvalid) begin
          if (b_cyc_q.size() == 0) fail_event("unexpected_bvalid");
          else chk("b_latency_cycle", cyc, b_cyc_q.pop_front());
        end
        if (bvalid && bready) begin
          if (b_resp_q.size() == 0) fail_event("unexpected_b_response");
          else chk("bresp", bresp, b_resp_q.pop_front());
          check_regs("regs_after_write");
          $display("B  resp=%0d cycle=%0d", bresp, cyc);
        end
        if (rvalid && rready) begin
          if (r_q.size() == 0) fail_event("unexpected_r_response");
          else begin
            r_exp = r_q.pop_front();
            chk("rresp", rresp, r_exp[33:32]);
            chk("rdata", rdata, r_exp[31:0]);
          end
          $display("R  resp=%0d data=0x%08h cycle=%0d", rresp, rdata, cyc);
        end
        if (wr_pulse) begin
          if (p_pulse) fail_event("wr_pulse_longer_than_one_cycle");
          if (idx_q.size() == 0) fail_event("unexpected_wr_pulse");
          else chk("wr_index", wr_index, idx_q.pop_front());
        end
        if (awvalid && awready) aw_pend = 1;
        if (wvalid && wready)   w_pend = 1;
        if (arvalid && arready) ar_pend = 1;
        if (bvalid && bready) begin aw_pend = 0; w_pend = 0; end
        if (rvalid && rready) ar_pend = 0;
        p_bvalid = bvalid; p_bhs = bvalid && bready; p_bresp = bresp;
        p_rvalid = rvalid; p_rhs = rvalid && rready; p_rresp = rresp; p_rdata = rdata;
        p_pulse = wr_pulse;
      end
    end
  end

  // ---------------- drivers (called at posedge+1) ----------------
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly);
    int t, last, idx;
    bit aw_done, w_done;
    t = 0; last = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done)) begin
      if (!aw_done && t >= aw_dly) begin awvalid = 1; awaddr = addr; end
      if (!w_done && t >= w_dly) begin wvalid = 1; wdata = data; wstrb = strb; end
      @(negedge clk);
      if (awvalid && awready) begin aw_done = 1; last = cyc; end
      if (wvalid && wready)   begin w_done = 1; last = cyc; end
      @(posedge clk); #1;
      if (aw_done) awvalid = 0;
      if (w_done)  wvalid = 0;
      t++;
      if (t > 60) begin
        fail_event("timeout_aw_w_handshake");
        awvalid = 0; wvalid = 0;
        return;
      end
    end
    idx = int'(addr >> 2);
    b_cyc_q.push_back(last + 2);
    if (idx < NR) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      b_resp_q.push_back(2'b00);
      idx_q.push_back(idx);
    end else begin
      b_resp_q.push_back(OOR_RESP);
    end
    $display("W  addr=0x%0h data=0x%08h strb=0x%0h", addr, data, strb);
  endtask

  task automatic do_b(input int hold, input bit early);
    int seen, t;
    seen = 0; t = 0;
    bready = early;
    forever begin
      @(negedge clk);
      if (bvalid && bready) break;
      if (bvalid) seen++;
      @(posedge clk); #1;
      if (seen >= hold) bready = 1;
      t++;
      if (t > 60) begin fail_event("timeout_b_handshake"); bready = 0; return; end
    end
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic do_ar(input logic [31:0] addr, input int pre);
    int idx, t;
    idx = int'(addr >> 2);
    r_q.push_back((idx < NR) ? {2'b00, model[idx]} : {OOR_RESP, 32'h0});
    repeat (pre) begin @(posedge clk); #1; end
    arvalid = 1; araddr = addr; t = 0;
    forever begin
      @(negedge clk);
      if (arvalid && arready) break;
      @(posedge clk); #1;
      t++;
      if (t > 60) begin fail_event("timeout_ar_handshake"); arvalid = 0; return; end
    end
    @(posedge clk); #1;
    arvalid = 0;
    $display("AR addr=0x%0h", addr);
  endtask

  task automatic do_r(input int hold, input bit early);
    int seen, t;
    seen = 0; t = 0;
    rready = early;
    forever begin
      @(negedge clk);
      if (rvalid && rready) break;
      if (rvalid) seen++;
      @(posedge clk); #1;
      if (seen >= hold) rready = 1;
      t++;
      if (t > 60) begin fail_event("timeout_r_handshake"); rready = 0; return; end
    end
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, awready, 0);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_arready"}, arready, 0);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_bresp"}, bresp, 0);
    chk({tag, "_rresp"}, rresp, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_wr_pulse"}, wr_pulse, 0);
    chk({tag, "_wr_index"}, wr_index, 0);
    check_regs({tag, "_regs"});
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] a, d;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_reset_aw", awready, 1);
    chk("ready_after_reset_ar", arready, 1);

    // Simultaneous AW/W, then read back.
    do_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 0);
    do_b(0, 0);
    chk("reg2_value", regs_out[2*32 +: 32], 32'hDEADBEEF);
    do_ar(32'h8, 0);
    do_r(0, 0);

    // AW leads W by three cycles, then W leads AW.
    do_write(32'h4, 32'h12345678, 4'hF, 0, 3);
    do_b(1, 0);
    do_write(32'h4, 32'h9ABCDEF0, 4'hF, 3, 0);
    do_b(0, 1);
    chk("reg1_value", regs_out[1*32 +: 32], 32'h9ABCDEF0);

    // Single byte lane.
    do_write(32'hC, 32'hFFFFFFFF, 4'hF, 0, 0);
    do_b(0, 0);
    do_write(32'hC, 32'h00AA0000, 4'h4, 0, 0);
    do_b(0, 0);
    chk("reg3_strobed", regs_out[3*32 +: 32], 32'hFFAAFFFF);
    do_ar(32'hC, 0);
    do_r(0, 1);

    // Back-pressure on B and R for five cycles.
    do_write(32'h14, 32'h11111111, 4'hF, 0, 0);
    do_b(5, 0);
    do_ar(32'h14, 0);
    do_r(5, 0);

    // Read sampled on the same edge the write executes: old value returned.
    fork
      do_write(32'h14, 32'h22222222, 4'hF, 0, 0);
      do_ar(32'h14, 1);
    join
    do_b(0, 0);
    do_r(0, 0);

    // Out of range.
    do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0);
    do_b(0, 0);
    do_ar(32'h40, 0);
    do_r(0, 0);

    // Reset while the write is in EXEC and the read sits in R_RESP.
    do_ar(32'h8, 0);
    do_write(32'h10, 32'h55555555, 4'hF, 0, 0);
    rst_n = 0;
    flush_queues();
    model_clear();
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    rst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_midreset_w", wready, 1);
    do_write(32'h10, 32'h0BADCAFE, 4'hF, 0, 0);
    do_b(0, 0);
    do_ar(32'h10, 0);
    do_r(0, 0);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      a = ($urandom_range(0, 17) << 2) | $urandom_range(0, 3);
      d = $urandom;
      do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      do_b($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      a = ($urandom_range(0, 17) << 2) | $urandom_range(0, 3);
      do_ar(a, 0);
      do_r($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("b_queue_drained", b_resp_q.size(), 0);
    chk("r_queue_drained", r_q.size(), 0);
    chk("wr_index_queue_drained", idx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
